sa_feed_ctrl: RTL and testbench

//  Sequencer for the skewed systolic array (ROW x COL grid plus row-delay registers).
//  On a start command, it reads LEN activation vectors from an activation buffer and drives them onto the array's west input with per-lane valid bits.
//  It counts valid samples reaching the last row, waits for the pipeline to drain, then pulses done.

---
 rtl/sa_feed_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_sa_feed_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_feed_ctrl.sv
// Feed sequencer for the skewed systolic array.
//
// On an accepted start it reads LEN activation vectors from the activation buffer and
// drives them onto the west edge of the array. It then counts valid samples at the last
// row, lets the pipeline drain, and pulses done.
//
// Ports:
//   in_clk, in_rst     clock and synchronous active-high reset
//   in_start           start command, only sampled in idle
//   in_base, in_len    first buffer address and vector count, captured with start
//   in_hold            feed stall; the array sees bubbles while it is high
//   out_rd_en          buffer read strobe
//   out_rd_addr        buffer read address (base + issued count, wraps)
//   in_rd_data         buffer read data, valid one cycle after out_rd_en
//   out_west           west bus, lane r = {valid, data} at bits [r*9 +: 9]
//   in_last_valid      valid flag from the last array row
//   out_busy           high while a tile is in flight (feed, drain, done)
//   out_done           one-cycle pulse at the end of a tile
module sa_feed_ctrl #(
  parameter int unsigned ROW      = 9,
  parameter int unsigned COL      = 1,
  parameter int unsigned PIPE_LAT = 1,
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic                in_clk,
  input  logic                in_rst,
  input  logic                in_start,
  input  logic [ADDR_W-1:0]   in_base,
  input  logic [LEN_W-1:0]    in_len,
  input  logic                in_hold,
  output logic                out_rd_en,
  output logic [ADDR_W-1:0]   out_rd_addr,
  input  logic [ROW*8-1:0]    in_rd_data,
  output logic [ROW*9-1:0]    out_west,
  input  logic                in_last_valid,
  output logic                out_busy,
  output logic                out_done
);

  // Cycles the last column and PE output stage need after the final last-row sample.
  localparam int unsigned DrainLen = COL + PIPE_LAT;
  localparam int unsigned TimerW   = (DrainLen < 2) ? 1 : $clog2(DrainLen + 1);

  typedef enum logic [1:0] {
    StIdle,
    StFeed,
    StDrain,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    issued_q, issued_d;
  logic [LEN_W-1:0]    lv_cnt_q, lv_cnt_d;
  logic                armed_q, armed_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                rd_en_q;

  logic                active;
  logic                lv_inc;
  logic                drain_done;

  // ---------------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q  <= StIdle;
      base_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      lv_cnt_q <= '0;
      armed_q  <= 1'b0;
      timer_q  <= '0;
      rd_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      lv_cnt_q <= lv_cnt_d;
      armed_q  <= armed_d;
      timer_q  <= timer_d;
      rd_en_q  <= out_rd_en;
    end
  end

  // ---------------------------------------------------------------------------
  // Last-row accounting and drain timer
  // ---------------------------------------------------------------------------
  assign active = (state_q == StFeed) || (state_q == StDrain);

  // Samples beyond len, or outside an active tile, are not counted.
  assign lv_inc = active && in_last_valid && (lv_cnt_q != len_q);

  // The timer is armed once the final sample has arrived; the step that takes it to
  // zero is the last drain cycle. A timer that already expired during feed also
  // completes the drain immediately.
  assign drain_done = armed_q && (timer_q <= TimerW'(1));

  always_comb begin
    lv_cnt_d = lv_cnt_q;
    armed_d  = armed_q;
    timer_d  = timer_q;

    if (state_q == StIdle) begin
      lv_cnt_d = '0;
      armed_d  = 1'b0;
      timer_d  = '0;
    end else if (lv_inc) begin
      lv_cnt_d = lv_cnt_q + 1'b1;
      if ((lv_cnt_q + 1'b1) == len_q) begin
        armed_d = 1'b1;
        timer_d = TimerW'(DrainLen);
      end
    end else if (armed_q && (timer_q != '0)) begin
      timer_d = timer_q - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM and read port
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    issued_d    = issued_q;
    out_rd_en   = 1'b0;
    out_rd_addr = '0;
    out_busy    = 1'b1;
    out_done    = 1'b0;

    unique case (state_q)
      StIdle: begin
        out_busy = 1'b0;
        if (in_start) begin
          base_d   = in_base;
          len_d    = in_len;
          issued_d = '0;
          state_d  = (in_len != '0) ? StFeed : StDone;
        end
      end

      StFeed: begin
        out_rd_en   = !in_hold;
        out_rd_addr = base_q + ADDR_W'(issued_q);
        if (out_rd_en) begin
          issued_d = issued_q + 1'b1;
          if (issued_q == (len_q - 1'b1)) begin
            state_d = StDrain;
          end
        end
      end

      StDrain: begin
        if (drain_done) begin
          state_d = StDone;
        end
      end

      StDone: begin
        out_done = 1'b1;
        state_d  = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // West drive: read data lands one cycle after the strobe, so the registered strobe
  // marks it valid. This also covers the final read returning in the first drain cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_west = '0;
    for (int r = 0; r < ROW; r++) begin
      if (rd_en_q) begin
        out_west[r*9 +: 9] = {1'b1, in_rd_data[r*8 +: 8]};
      end
    end
  end

endmodule

// File: tb/tb_sa_feed_ctrl.sv
module tb_sa_feed_ctrl;

  localparam int unsigned ROW      = 9;
  localparam int unsigned COL      = 1;
  localparam int unsigned PIPE_LAT = 1;
  localparam int unsigned LEN_W    = 8;
  localparam int unsigned ADDR_W   = 10;
  // Skew from west input to last-row valid in the array model below.
  localparam int unsigned LD       = 3;

  logic                clk;
  logic                in_rst;
  logic                in_start;
  logic [ADDR_W-1:0]   in_base;
  logic [LEN_W-1:0]    in_len;
  logic                in_hold;
  logic                out_rd_en;
  logic [ADDR_W-1:0]   out_rd_addr;
  logic [ROW*8-1:0]    in_rd_data;
  logic [ROW*9-1:0]    out_west;
  logic                in_last_valid;
  logic                out_busy;
  logic                out_done;

  sa_feed_ctrl #(
    .ROW      (ROW),
    .COL      (COL),
    .PIPE_LAT (PIPE_LAT),
    .LEN_W    (LEN_W),
    .ADDR_W   (ADDR_W)
  ) dut (
    .in_clk        (clk),
    .in_rst        (in_rst),
    .in_start      (in_start),
    .in_base       (in_base),
    .in_len        (in_len),
    .in_hold       (in_hold),
    .out_rd_en     (out_rd_en),
    .out_rd_addr   (out_rd_addr),
    .in_rd_data    (in_rd_data),
    .out_west      (out_west),
    .in_last_valid (in_last_valid),
    .out_busy      (out_busy),
    .out_done      (out_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int s_cyc    = 0;
  int done_cnt = 0;
  int lv_cnt   = 0;
  int last_lv_cyc = 0;

  logic [ADDR_W-1:0] exp_addr[$];
  logic [ROW*9-1:0]  exp_west[$];
  logic [LD-1:0]     lv_sr;

  always @(posedge clk) cyc <= cyc + 1;

  // Buffer contents as a function of address.
  function automatic logic [ROW*8-1:0] mem_word(input logic [ADDR_W-1:0] a);
    logic [ROW*8-1:0] w;
    for (int r = 0; r < ROW; r++) w[r*8 +: 8] = 8'(a * 13 + r * 37 + 5);
    return w;
  endfunction

  function automatic logic [ROW*9-1:0] west_word(input logic [ADDR_W-1:0] a);
    logic [ROW*8-1:0] d;
    logic [ROW*9-1:0] w;
    d = mem_word(a);
    for (int r = 0; r < ROW; r++) w[r*9 +: 9] = {1'b1, d[r*8 +: 8]};
    return w;
  endfunction

  // Synchronous-read buffer and a fixed-skew array model.
  always @(posedge clk) begin
    if (out_rd_en) in_rd_data <= mem_word(out_rd_addr);
    if (in_rst) lv_sr <= '0;
    else        lv_sr <= {lv_sr[LD-2:0], out_west[8]};
  end
  assign in_last_valid = lv_sr[LD-1];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: reads and west words are popped as the DUT produces them.
  always @(negedge clk) begin
    if (!in_rst) begin
      if (out_rd_en) begin
        if (exp_addr.size() == 0) chk("rd_unexpected", out_rd_en, 1'b0);
        else chk("rd_addr", out_rd_addr, exp_addr.pop_front());
      end
      if (out_west[8]) begin
        if (exp_west.size() == 0) chk("west_unexpected", out_west, '0);
        else chk("west_data", out_west, exp_west.pop_front());
      end else begin
        chk("west_bubble", out_west, '0);
      end
      if (in_last_valid) begin
        lv_cnt++;
        last_lv_cyc = cyc;
      end
      if (out_done) begin
        done_cnt++;
        if (lv_cnt > 0) chk("done_gap", cyc - last_lv_cyc, 1 + COL + PIPE_LAT);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tile(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len);
    in_start = 1'b1;
    in_base  = base;
    in_len   = len;
    lv_cnt   = 0;
    for (int i = 0; i < int'(len); i++) begin
      exp_addr.push_back(ADDR_W'(base + i));
      exp_west.push_back(west_word(ADDR_W'(base + i)));
    end
    s_cyc = cyc;
    step();
    in_start = 1'b0;
  endtask

  // Returns in the done cycle.
  task automatic wait_done(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (!out_done && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_done"}, out_done, 1'b1);
    if (out_done) begin
      chk({tag, "_latency"}, cyc - s_cyc, exp_lat);
      chk({tag, "_busy_in_done"}, out_busy, 1'b1);
    end
  endtask

  task automatic finish_idle(input string tag);
    step();
    chk({tag, "_busy_after"}, out_busy, 1'b0);
    chk({tag, "_done_after"}, out_done, 1'b0);
    chk({tag, "_addr_q_empty"}, exp_addr.size(), 0);
    chk({tag, "_west_q_empty"}, exp_west.size(), 0);
  endtask

  int d0;

  initial begin
    in_rst   = 1'b1;
    in_start = 1'b0;
    in_base  = '0;
    in_len   = '0;
    in_hold  = 1'b0;
    in_rd_data = '0;
    repeat (3) step();
    in_rst = 1'b0;
    step();
    chk("rst_rd_en", out_rd_en, 1'b0);
    chk("rst_addr", out_rd_addr, '0);
    chk("rst_west", out_west, '0);
    chk("rst_busy", out_busy, 1'b0);
    chk("rst_done", out_done, 1'b0);

    // Plain tile.
    d0 = done_cnt;
    start_tile(10'h010, 8'd4);
    chk("t1_busy", out_busy, 1'b1);
    wait_done("t1", 4 + LD + 2 + COL + PIPE_LAT);
    finish_idle("t1");
    chk("t1_done_count", done_cnt - d0, 1);

    // Two-cycle hold after the second read.
    d0 = done_cnt;
    start_tile(10'h010, 8'd4);
    step();
    step();
    in_hold = 1'b1;
    #1;
    chk("t2_hold_rd0", out_rd_en, 1'b0);
    step();
    chk("t2_hold_rd1", out_rd_en, 1'b0);
    chk("t2_bubble0", out_west, '0);
    step();
    in_hold = 1'b0;
    chk("t2_bubble1", out_west, '0);
    wait_done("t2", 4 + 2 + LD + 2 + COL + PIPE_LAT);
    finish_idle("t2");
    chk("t2_done_count", done_cnt - d0, 1);

    // Zero-length tile.
    d0 = done_cnt;
    start_tile(10'h010, 8'd0);
    chk("t3_rd_en", out_rd_en, 1'b0);
    wait_done("t3", 1);
    finish_idle("t3");
    chk("t3_done_count", done_cnt - d0, 1);

    // Address wrap.
    start_tile(10'h3FE, 8'd4);
    wait_done("t4", 4 + LD + 2 + COL + PIPE_LAT);
    finish_idle("t4");

    // Reset mid-feed after two reads.
    d0 = done_cnt;
    start_tile(10'h020, 8'd4);
    step();
    in_rst = 1'b1;
    step();
    in_rst = 1'b0;
    #1;
    chk("t5_rd_en", out_rd_en, 1'b0);
    chk("t5_west", out_west, '0);
    chk("t5_busy", out_busy, 1'b0);
    chk("t5_done", out_done, 1'b0);
    exp_addr.delete();
    exp_west.delete();
    repeat (6) step();
    chk("t5_no_done", done_cnt - d0, 0);
    start_tile(10'h030, 8'd1);
    wait_done("t5b", 1 + LD + 2 + COL + PIPE_LAT);
    finish_idle("t5b");
    chk("t5_done_count", done_cnt - d0, 1);

    // Starts during feed and on the done cycle are ignored.
    d0 = done_cnt;
    start_tile(10'h040, 8'd3);
    in_start = 1'b1;
    in_base  = 10'h155;
    in_len   = 8'd7;
    step();
    in_start = 1'b0;
    wait_done("t6", 3 + LD + 2 + COL + PIPE_LAT);
    in_start = 1'b1;
    in_base  = 10'h060;
    in_len   = 8'd5;
    step();
    in_start = 1'b0;
    #1;
    chk("t6_busy_after", out_busy, 1'b0);
    chk("t6_rd_after", out_rd_en, 1'b0);
    repeat (8) step();
    chk("t6_still_idle", out_busy, 1'b0);
    chk("t6_done_count", done_cnt - d0, 1);
    chk("t6_addr_q_empty", exp_addr.size(), 0);
    chk("t6_west_q_empty", exp_west.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
